mode_controller: RTL and testbench
==================================

MODE_CONTROLLER -- requirements
Module: mode_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 500; idle clk cycles in ADJUST before abandoning edits.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 up, down, left, right, center  input  1 each  one-cycle button pulses from the Buttons stage.
REQ-005 cur_hr  input  5  running clock hour, 0..23; cur_min  input  6  running clock minute, 0..59.
REQ-006 adjust  output  1  high while in ADJUST state.
REQ-007 sel  output  2  field under edit: 0 clock hour, 1 clock minute, 2 alarm hour, 3 alarm minute.
REQ-008 set_hr  output  5  and set_min  output  6  edited clock time, valid when time_load is high.
REQ-009 time_load  output  1  one-cycle strobe commanding the time counter to load set_hr/set_min.
REQ-010 alm_hr  output  5, alm_min  output  6  stored alarm time; alm_en  output  1  alarm armed.

Function
REQ-011 FSM states: RUN and ADJUST; the reset state is RUN.
REQ-012 Per-cycle pulse priority: center > right > left > up > down; at most one pulse acts per cycle, and the rest are ignored.
REQ-013 RUN + center: next state ADJUST, sel=0, edit registers loaded from cur_hr/cur_min in the same edge, and idle counter cleared.
REQ-014 RUN + up or down: toggle alm_en. Left and right in RUN have no effect.
REQ-015 ADJUST + right: sel=(sel+1) mod 4. ADJUST + left: sel=(sel-1) mod 4. sel=3 wraps to 0 and sel=0 wraps to 3.
REQ-016 ADJUST + up: increment the selected field. ADJUST + down: decrement the selected field.
REQ-017 Hour fields wrap 23->0 on up and 0->23 on down.
REQ-018 Minute fields wrap 59->0 on up and 0->59 on down.
REQ-019 Minute wrap does not carry into the hour.
REQ-020 Alarm fields (sel 2,3) update alm_hr/alm_min directly; alarm changes persist on any exit.
REQ-021 ADJUST + center: next state RUN, and time_load=1 for exactly the cycle after the center edge.
REQ-022 During the time_load cycle, set_hr/set_min hold the edited values.
REQ-023 Idle counter increments every ADJUST cycle with no accepted pulse and clears on any accepted pulse.
REQ-024 When the idle count reaches TIMEOUT_CYCLES-1, return to RUN on that edge with no time_load; clock edits are discarded and alarm edits are kept.
REQ-025 A timeout and a center pulse in the same cycle resolve as center, so the load occurs.
REQ-026 time_load is low at all times except the cycle required by REQ-021.
REQ-027 The set_hr/set_min edit registers never hold out-of-range values; all outputs are registered.

Reset
REQ-028 Asserting rst (low) at any time, including mid-ADJUST or during the time_load cycle, forces the following values immediately:
- state RUN, adjust=0, sel=0, time_load=0
- set_hr=0, set_min=0
- alm_hr=0, alm_min=0, alm_en=0
- idle counter=0
REQ-029 After rst deasserts, the first pulse is honoured on the first rising edge.

Structure
REQ-030 The shared package alarm_clock_pkg holds:
- state enum (RUN, ADJUST)
- field encodings SEL_CLK_HR=0, SEL_CLK_MIN=1, SEL_ALM_HR=2, SEL_ALM_MIN=3
- constants HR_MAX=23, MIN_MAX=59
REQ-031 The wrap arithmetic lives in one combinational sub-module, mod_updown: value, max, inc and dec in; wrapped value out. It is instantiated per field width.
REQ-032 Width of the idle counter is $clog2(TIMEOUT_CYCLES).

Verification
REQ-033 Load path: cur=13:45; pulse center, then up x2 (hour 15), right, down (min 44), center.
- Required: time_load high exactly one cycle with set=15:44, then adjust=0.
REQ-034 Wrap: in ADJUST, sel=0, hour=23: pulse up -> 0, then down -> 23.
- Required: sel=1, min=0: pulse down -> 59.
- Required: left from sel=0 -> sel=3.
REQ-035 Alarm and timeout: enter ADJUST, right x2, up x7 (alm_hr=7), then idle TIMEOUT_CYCLES cycles.
- Required: return to RUN with no time_load, alm_hr=7 retained.
REQ-036 Simultaneous pulses: same cycle center+up in ADJUST.
- Required: center wins, time_load fires, and the field is unchanged.
- Required: center coincident with the timeout edge still produces the load.
REQ-037 Mid-operation reset: assert rst low during ADJUST with edits pending, and during the time_load cycle.
- Required: all outputs go to reset values asynchronously, and no further time_load occurs.
REQ-038 RUN toggles: up -> alm_en=1, down -> alm_en=0.
- Required: left/right in RUN leave all outputs unchanged.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm clock mode controller.
package alarm_clock_pkg;

  // Controller modes.
  typedef enum logic {
    RUN    = 1'b0,
    ADJUST = 1'b1
  } state_t;

  // Field under edit.
  localparam logic [1:0] SEL_CLK_HR  = 2'd0;
  localparam logic [1:0] SEL_CLK_MIN = 2'd1;
  localparam logic [1:0] SEL_ALM_HR  = 2'd2;
  localparam logic [1:0] SEL_ALM_MIN = 2'd3;

  // Largest legal value of each field.
  localparam logic [4:0] HR_MAX  = 5'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;

  // The edit registers are seeded from the running clock; an out-of-range
  // value there is replaced by zero so the edit registers stay legal.
  function automatic logic [4:0] sane_hr(input logic [4:0] h);
    return (h > HR_MAX) ? 5'd0 : h;
  endfunction

  function automatic logic [5:0] sane_min(input logic [5:0] m);
    return (m > MIN_MAX) ? 6'd0 : m;
  endfunction

endpackage

// File: rtl/mod_updown.sv
// Wrapping up/down step of a field in the range 0..max. inc has priority
// over dec; with neither asserted the value passes through unchanged.
module mod_updown #(
  parameter int W = 6
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] max,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] result
);

  // Increment wraps max->0, decrement wraps 0->max.
  always_comb begin
    result = value;
    if (inc) begin
      result = (value >= max) ? '0 : value + 1'b1;
    end else if (dec) begin
      result = ((value == '0) || (value > max)) ? max : value - 1'b1;
    end
  end

endmodule

// File: rtl/mode_controller.sv
// Mode controller for the alarm clock: RUN/ADJUST FSM, field editing,
// alarm arming and the time-load strobe to the time counter.
//
// Strobe contract: time_load is a one-cycle command with no back-pressure.
// set_hr/set_min are valid exactly in the cycle time_load is high; the
// time counter must capture them in that cycle.
module mode_controller
  import alarm_clock_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       center,
  input  logic [4:0] cur_hr,
  input  logic [5:0] cur_min,
  output logic       adjust,
  output logic [1:0] sel,
  output logic [4:0] set_hr,
  output logic [5:0] set_min,
  output logic       time_load,
  output logic [4:0] alm_hr,
  output logic [5:0] alm_min,
  output logic       alm_en,
  output state_t     fsm_state
);

  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_next;
  logic [1:0]        sel_next;
  logic [4:0]        set_hr_next, alm_hr_next;
  logic [5:0]        set_min_next, alm_min_next;
  logic              alm_en_next, time_load_next;
  logic [IDLE_W-1:0] idle_cnt, idle_next;

  // Single winning pulse per cycle: center > right > left > up > down.
  logic act_center, act_right, act_left, act_up, act_down, act_any;
  assign act_center = center;
  assign act_right  = right & ~center;
  assign act_left   = left  & ~center & ~right;
  assign act_up     = up    & ~center & ~right & ~left;
  assign act_down   = down  & ~center & ~right & ~left & ~up;
  assign act_any    = act_center | act_right | act_left | act_up | act_down;

  // One wrap unit per field width; the source is the selected register.
  logic       field_inc, field_dec;
  logic [4:0] hr_src, hr_wrapped;
  logic [5:0] min_src, min_wrapped;
  assign field_inc = act_up   & (state == ADJUST);
  assign field_dec = act_down & (state == ADJUST);
  assign hr_src    = (sel == SEL_ALM_HR)  ? alm_hr  : set_hr;
  assign min_src   = (sel == SEL_ALM_MIN) ? alm_min : set_min;

  mod_updown #(.W(5)) u_hr_wrap (
    .value (hr_src),
    .max   (HR_MAX),
    .inc   (field_inc),
    .dec   (field_dec),
    .result(hr_wrapped)
  );

  mod_updown #(.W(6)) u_min_wrap (
    .value (min_src),
    .max   (MIN_MAX),
    .inc   (field_inc),
    .dec   (field_dec),
    .result(min_wrapped)
  );

  assign adjust    = (state == ADJUST);
  assign fsm_state = state;

  // Next-state and next-register decode; hold everything by default.
  always_comb begin
    state_next     = state;
    sel_next       = sel;
    set_hr_next    = set_hr;
    set_min_next   = set_min;
    alm_hr_next    = alm_hr;
    alm_min_next   = alm_min;
    alm_en_next    = alm_en;
    time_load_next = 1'b0;
    idle_next      = idle_cnt;
    case (state)
      RUN: begin
        if (act_center) begin
          state_next   = ADJUST;
          sel_next     = SEL_CLK_HR;
          set_hr_next  = sane_hr(cur_hr);
          set_min_next = sane_min(cur_min);
          idle_next    = '0;
        end else if (act_up || act_down) begin
          alm_en_next = ~alm_en;
        end
      end
      ADJUST: begin
        if (act_center) begin
          // Center beats a coincident timeout, so the load still happens.
          state_next     = RUN;
          time_load_next = 1'b1;
          idle_next      = '0;
        end else if (act_any) begin
          idle_next = '0;
          if (act_right) sel_next = sel + 2'd1;
          if (act_left)  sel_next = sel - 2'd1;
          if (act_up || act_down) begin
            case (sel)
              SEL_CLK_HR:  set_hr_next  = hr_wrapped;
              SEL_CLK_MIN: set_min_next = min_wrapped;
              SEL_ALM_HR:  alm_hr_next  = hr_wrapped;
              default:     alm_min_next = min_wrapped;
            endcase
          end
        end else if (idle_cnt == IDLE_LAST) begin
          // Abandon clock edits; alarm edits were written in place and stay.
          state_next = RUN;
          idle_next  = '0;
        end else begin
          idle_next = idle_cnt + 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_next;
  end

  // Datapath registers: edit fields, alarm, strobe and idle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel       <= SEL_CLK_HR;
      set_hr    <= '0;
      set_min   <= '0;
      alm_hr    <= '0;
      alm_min   <= '0;
      alm_en    <= 1'b0;
      time_load <= 1'b0;
      idle_cnt  <= '0;
    end else begin
      sel       <= sel_next;
      set_hr    <= set_hr_next;
      set_min   <= set_min_next;
      alm_hr    <= alm_hr_next;
      alm_min   <= alm_min_next;
      alm_en    <= alm_en_next;
      time_load <= time_load_next;
      idle_cnt  <= idle_next;
    end
  end

endmodule

// File: tb/tb_mode_controller.sv
// Directed bench for mode_controller with an expected-output queue and a
// monitor that compares after every clock edge that has an expectation.
module tb_mode_controller;
  import alarm_clock_pkg::*;

  localparam int TO = 20;
  localparam int W  = 27;
  localparam logic [4:0] P_C  = 5'b10000;
  localparam logic [4:0] P_R  = 5'b01000;
  localparam logic [4:0] P_L  = 5'b00100;
  localparam logic [4:0] P_UP = 5'b00010;
  localparam logic [4:0] P_DN = 5'b00001;
  localparam logic [4:0] P_0  = 5'b00000;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       up, down, left, right, center;
  logic [4:0] cur_hr;
  logic [5:0] cur_min;
  logic       adjust, time_load, alm_en;
  logic [1:0] sel;
  logic [4:0] set_hr, alm_hr;
  logic [5:0] set_min, alm_min;
  state_t     fsm_state;

  always #5 clk = ~clk;

  mode_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .up(up), .down(down), .left(left), .right(right), .center(center),
    .cur_hr(cur_hr), .cur_min(cur_min),
    .adjust(adjust), .sel(sel), .set_hr(set_hr), .set_min(set_min),
    .time_load(time_load), .alm_hr(alm_hr), .alm_min(alm_min),
    .alm_en(alm_en), .fsm_state(fsm_state)
  );

  logic [W-1:0] dut_vec;
  assign dut_vec = {adjust, sel, set_hr, set_min, time_load, alm_hr, alm_min, alm_en};

  // ---------------- expectations ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  string        name_q[$];

  logic       e_adj, e_load, e_aen, c_sel, c_set;
  logic [1:0] e_sel;
  logic [4:0] e_shr, e_ahr;
  logic [5:0] e_smin, e_amin;

  function automatic logic [W-1:0] exp_vec();
    return {e_adj, e_sel, e_shr, e_smin, e_load, e_ahr, e_amin, e_aen};
  endfunction

  // sel and set_* are left unconstrained where their value is not defined.
  function automatic logic [W-1:0] exp_mask();
    logic [W-1:0] m;
    m = '1;
    if (!c_sel) m[25:24] = 2'b00;
    if (!c_set) m[23:13] = '0;
    return m;
  endfunction

  task automatic check(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] exp, input logic [W-1:0] mask);
    checks++;
    if ((got & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s got=%h required=%h care=%h t=%0t", name, got, exp, mask, $time);
    end
  endtask

  task automatic clear_exp();
    e_adj = 0; e_load = 0; e_aen = 0; e_sel = 0;
    e_shr = 0; e_smin = 0; e_ahr = 0; e_amin = 0;
    c_sel = 1; c_set = 1;
  endtask

  task automatic push_exp(input string name);
    exp_q.push_back(exp_vec());
    mask_q.push_back(exp_mask());
    name_q.push_back(name);
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive pulses for one rising edge and record
  // the outputs required after that edge.
  task automatic tick(input logic [4:0] p, input string name);
    {center, right, left, up, down} = p;
    push_exp(name);
    @(posedge clk);
    #1 {center, right, left, up, down} = P_0;
    @(negedge clk);
  endtask

  task automatic enter(input logic [4:0] h, input logic [5:0] m, input string name);
    cur_hr = h; cur_min = m;
    c_sel = 1; c_set = 1;
    e_adj = 1; e_sel = 0; e_shr = h; e_smin = m;
    tick(P_C, name);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      logic [W-1:0] e, m;
      string n;
      e = exp_q.pop_front();
      m = mask_q.pop_front();
      n = name_q.pop_front();
      check(n, dut_vec, e, m);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog bench did not complete t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    {center, right, left, up, down} = P_0;
    cur_hr = 5'd13; cur_min = 6'd45;
    clear_exp();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 check("reset_values", dut_vec, '0, '1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // RUN: up/down toggle arming, left/right do nothing.
    e_aen = 1; tick(P_UP, "run_up_arms");
    e_aen = 0; tick(P_DN, "run_down_disarms");
    tick(P_L, "run_left_noop");
    tick(P_R, "run_right_noop");
    tick(P_0, "run_idle");

    // Load path 13:45 -> 15:44.
    enter(5'd13, 6'd45, "enter_13_45");
    e_shr = 14; tick(P_UP, "hr_up_14");
    e_shr = 15; tick(P_UP, "hr_up_15");
    e_sel = 1;  tick(P_R, "sel_right_1");
    e_smin = 44; tick(P_DN, "min_down_44");
    e_adj = 0; e_load = 1; c_sel = 0;
    tick(P_C, "load_15_44");
    e_load = 0; c_set = 0;
    tick(P_0, "load_one_cycle");
    tick(P_0, "run_after_load");

    // Wrap behaviour.
    enter(5'd23, 6'd0, "enter_23_00");
    e_shr = 0;   tick(P_UP, "hr_wrap_up");
    e_shr = 23;  tick(P_DN, "hr_wrap_down");
    e_sel = 1;   tick(P_R, "sel_to_min");
    e_smin = 59; tick(P_DN, "min_wrap_down");
    e_smin = 0;  tick(P_UP, "min_wrap_no_carry");
    e_sel = 0;   tick(P_L, "sel_left_0");
    e_sel = 3;   tick(P_L, "sel_wrap_left");
    e_sel = 0;   tick(P_R, "sel_wrap_right");
    e_adj = 0; e_load = 1; c_sel = 0;
    tick(P_C, "load_23_00");
    e_load = 0; c_set = 0;
    tick(P_0, "run_after_wrap");

    // Simultaneous pulses.
    cur_hr = 5'd10; cur_min = 6'd20;
    c_sel = 1; c_set = 1; e_adj = 1; e_sel = 0; e_shr = 10; e_smin = 20;
    tick(P_C | P_DN, "run_center_beats_down");
    e_sel = 1;  tick(P_R | P_UP | P_DN, "right_beats_updown");
    e_sel = 0;  tick(P_L | P_UP, "left_beats_up");
    e_shr = 11; tick(P_UP | P_DN, "up_beats_down");
    e_adj = 0; e_load = 1; c_sel = 0;
    tick(P_C | P_UP, "center_beats_up");
    e_load = 0; c_set = 0;
    tick(P_0, "run_after_simul");

    // Alarm edits, then idle timeout.
    enter(5'd5, 6'd30, "enter_5_30");
    e_sel = 1; tick(P_R, "sel_1");
    e_sel = 2; tick(P_R, "sel_alm_hr");
    for (int i = 1; i <= 7; i++) begin
      e_ahr = 5'(i);
      tick(P_UP, "alm_hr_up");
    end
    e_sel = 3;   tick(P_R, "sel_alm_min");
    e_amin = 59; tick(P_DN, "alm_min_wrap");
    for (int i = 0; i < TO - 1; i++) tick(P_0, "idle_hold");
    e_adj = 0; c_sel = 0; c_set = 0;
    tick(P_0, "timeout_exit_no_load");
    tick(P_0, "after_timeout_1");
    tick(P_0, "after_timeout_2");

    // Center on the timeout edge still loads.
    enter(5'd8, 6'd9, "enter_8_09");
    for (int i = 0; i < TO - 1; i++) tick(P_0, "idle_hold2");
    e_adj = 0; e_load = 1; c_sel = 0;
    tick(P_C, "center_at_timeout");
    e_load = 0; c_set = 0;
    tick(P_0, "run_after_center_timeout");
    e_aen = 1; tick(P_UP, "run_arm_again");

    // Reset in the middle of ADJUST with a pending edit.
    enter(5'd2, 6'd3, "enter_2_03");
    e_shr = 3; tick(P_UP, "hr_up_3");
    #3 rst = 1'b0;
    #1 check("rst_mid_adjust", dut_vec, '0, '1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_exp();
    repeat (3) tick(P_0, "idle_after_rst");

    // Reset during the time_load cycle.
    enter(5'd4, 6'd5, "enter_4_05");
    e_adj = 0; e_load = 1; c_sel = 0;
    push_exp("load_4_05");
    center = 1'b1;
    @(posedge clk);
    #1 center = 1'b0;
    #3 rst = 1'b0;
    #1 check("rst_in_load_cycle", dut_vec, '0, '1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_exp();
    e_aen = 1; tick(P_UP, "first_pulse_after_rst");
    repeat (3) tick(P_0, "no_load_after_rst");

    // Drain and report.
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
